// File: rtl/axo_mem_arbiter.sv
// Round-robin arbiter sharing one memory-bus target between several requesters.
// The grant is held until the target answers; an optional watchdog ends stuck accesses.
module axo_mem_arbiter #(
  parameter int alen    = 32,
  parameter int dlen    = 32,
  parameter int ports   = 2,
  parameter int timeout = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ports-1:0]           req_re,
  input  logic [ports-1:0]           req_we,
  input  logic [2*ports-1:0]         req_asize,
  input  logic [alen*ports-1:0]      req_addr,
  input  logic [dlen*ports-1:0]      req_wdata,
  output logic [dlen*ports-1:0]      req_rdata,
  output logic [ports-1:0]           req_ready,
  output logic [ports-1:0]           req_error,
  output logic                       tgt_re,
  output logic                       tgt_we,
  output logic [1:0]                 tgt_asize,
  output logic [alen-1:0]            tgt_addr,
  output logic [dlen-1:0]            tgt_wdata,
  input  logic [dlen-1:0]            tgt_rdata,
  input  logic                       tgt_ready,
  input  logic                       tgt_error,
  output logic                       busy,
  output logic [$clog2(ports)-1:0]   grant_id
);

  localparam int IW = $clog2(ports);
  localparam int CW = (timeout > 0) ? $clog2(timeout + 1) : 1;

  // Handshake: an access of requester i is offered while req_re[i]|req_we[i]
  // is high and all its fields are held; it completes in the cycle req_ready[i]
  // is high (req_error/req_rdata valid only then). The target side mirrors this
  // with tgt_re/tgt_we as the request and tgt_ready as completion.
  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   prio, prio_next;
  logic [IW-1:0]   owner, owner_next;
  logic [CW-1:0]   count, count_next;

  logic [ports-1:0] active;
  logic [IW-1:0]    winner;
  logic             win_valid;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    sel;

  assign active = req_re | req_we;

  function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
    return (int'(i) == ports - 1) ? '0 : i + IW'(1);
  endfunction

  // First active requester at or after the priority pointer, wrapping around.
  always_comb begin
    winner    = '0;
    win_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < ports; k++) begin
      idx = IW'((int'(prio) + k) % ports);
      if (!win_valid && active[idx]) begin
        winner    = idx;
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    prio_next  = prio;
    owner_next = owner;
    count_next = count;
    tgt_re     = 1'b0;
    tgt_we     = 1'b0;
    tgt_asize  = '0;
    tgt_addr   = '0;
    tgt_wdata  = '0;
    req_ready  = '0;
    req_error  = '0;
    req_rdata  = '0;
    busy       = 1'b0;
    grant_id   = '0;
    sel        = (state == BUSY) ? owner : winner;

    if ((state == IDLE && win_valid) || state == BUSY) begin
      grant_id  = sel;
      tgt_re    = req_re[sel];
      tgt_we    = req_we[sel];
      tgt_asize = req_asize[int'(sel)*2 +: 2];
      tgt_addr  = req_addr[int'(sel)*alen +: alen];
      tgt_wdata = req_wdata[int'(sel)*dlen +: dlen];
    end

    case (state)
      IDLE: begin
        if (win_valid) begin
          if (tgt_ready) begin
            req_ready[sel]                 = 1'b1;
            req_error[sel]                 = tgt_error;
            req_rdata[int'(sel)*dlen +: dlen] = tgt_rdata;
            prio_next                      = inc_idx(sel);
          end else begin
            owner_next = sel;
            count_next = CW'(1);
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (!active[sel]) begin
          // Owner withdrew mid-access: abandon quietly, fairness pointer untouched.
          state_next = IDLE;
        end else if (tgt_ready) begin
          req_ready[sel]                 = 1'b1;
          req_error[sel]                 = tgt_error;
          req_rdata[int'(sel)*dlen +: dlen] = tgt_rdata;
          prio_next                      = inc_idx(sel);
          state_next                     = IDLE;
        end else if (timeout > 0 && count == CW'(timeout)) begin
          tgt_re         = 1'b0;
          tgt_we         = 1'b0;
          req_ready[sel] = 1'b1;
          req_error[sel] = 1'b1;
          prio_next      = inc_idx(sel);
          state_next     = IDLE;
        end else begin
          count_next = count + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio  <= '0;
      owner <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      prio  <= prio_next;
      owner <= owner_next;
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_axo_mem_arbiter.sv
// Directed bench for axo_mem_arbiter (2 ports, watchdog 4): driver pushes expected
// responses into a queue, a negedge monitor pops them on every req_ready.
module tb_axo_mem_arbiter;

  localparam int AL = 32;
  localparam int DL = 32;
  localparam int NP = 2;
  localparam int TO = 4;
  localparam int W  = 1 + 1 + DL;   // {port, error, rdata}

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req_re, req_we;
  logic [2*NP-1:0]   req_asize;
  logic [AL*NP-1:0]  req_addr;
  logic [DL*NP-1:0]  req_wdata;
  logic [DL*NP-1:0]  req_rdata;
  logic [NP-1:0]     req_ready, req_error;
  logic              tgt_re, tgt_we;
  logic [1:0]        tgt_asize;
  logic [AL-1:0]     tgt_addr;
  logic [DL-1:0]     tgt_wdata;
  logic [DL-1:0]     tgt_rdata;
  logic              tgt_ready, tgt_error;
  logic              busy;
  logic [0:0]        grant_id;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit done  = 1'b0;

  axo_mem_arbiter #(.alen(AL), .dlen(DL), .ports(NP), .timeout(TO)) dut (
    .clk(clk), .rst(rst),
    .req_re(req_re), .req_we(req_we), .req_asize(req_asize),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rdata(req_rdata),
    .req_ready(req_ready), .req_error(req_error),
    .tgt_re(tgt_re), .tgt_we(tgt_we), .tgt_asize(tgt_asize),
    .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata), .tgt_rdata(tgt_rdata),
    .tgt_ready(tgt_ready), .tgt_error(tgt_error),
    .busy(busy), .grant_id(grant_id)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_re    = '0;
    req_we    = '0;
    req_asize = '0;
    req_addr  = '0;
    req_wdata = '0;
    tgt_rdata = '0;
    tgt_ready = 1'b0;
    tgt_error = 1'b0;
  endtask

  function automatic logic [W-1:0] pack(input int port, input logic err, input logic [DL-1:0] d);
    return {1'(port), err, d};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!done && !rst) begin
      for (int p = 0; p < NP; p++) begin
        if (req_ready[p]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ready", 64'(p), 64'hFFFF);
          end else begin
            check("response", 64'(pack(p, req_error[p], req_rdata[p*DL +: DL])), 64'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    sample();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_tgt_rw", 64'({tgt_re, tgt_we}), 64'd0);
    tick();
    rst = 1'b0;

    // single read, same-cycle target answer
    req_re[0] = 1'b1; req_addr[31:0] = 32'h100; req_asize[1:0] = 2'd2;
    tgt_ready = 1'b1; tgt_rdata = 32'hDEADBEEF;
    exp_q.push_back(pack(0, 1'b0, 32'hDEADBEEF));
    sample();
    check("t1_tgt_re", 64'(tgt_re), 64'd1);
    check("t1_tgt_addr", 64'(tgt_addr), 64'h100);
    check("t1_tgt_asize", 64'(tgt_asize), 64'd2);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_grant", 64'(grant_id), 64'd0);
    tick();
    idle_inputs();

    // contention: prio now 1, so grants go 1,0,1,0
    req_re = 2'b11; req_addr[31:0] = 32'h200; req_addr[63:32] = 32'h300;
    tgt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int w;
      w = (k % 2 == 0) ? 1 : 0;
      tgt_rdata = 32'hA000_0000 + 32'(k);
      exp_q.push_back(pack(w, 1'b0, 32'hA000_0000 + 32'(k)));
      sample();
      check("t2_grant", 64'(grant_id), 64'(w));
      check("t2_tgt_addr", 64'(tgt_addr), (w == 1) ? 64'h300 : 64'h200);
      check("t2_busy", 64'(busy), 64'd0);
      tick();
    end
    idle_inputs();

    // stall hold: port 1 write holds the bus while port 0 waits
    req_we[1] = 1'b1; req_addr[63:32] = 32'h104; req_wdata[63:32] = 32'h12345678;
    req_re[0] = 1'b1; req_addr[31:0] = 32'h108;
    sample();
    check("t3_grant_a", 64'(grant_id), 64'd1);
    check("t3_tgt_we", 64'(tgt_we), 64'd1);
    check("t3_tgt_wdata", 64'(tgt_wdata), 64'h12345678);
    check("t3_busy_a", 64'(busy), 64'd0);
    for (int b = 1; b <= 3; b++) begin
      tick();
      if (b == 3) begin
        tgt_ready = 1'b1;
        exp_q.push_back(pack(1, 1'b0, 32'h0));
      end
      sample();
      check("t3_busy", 64'(busy), 64'd1);
      check("t3_hold_addr", 64'(tgt_addr), 64'h104);
      check("t3_hold_grant", 64'(grant_id), 64'd1);
    end
    tick();
    req_we[1] = 1'b0;
    tgt_rdata = 32'h0BADF00D;
    exp_q.push_back(pack(0, 1'b0, 32'h0BADF00D));
    sample();
    check("t3_next_grant", 64'(grant_id), 64'd0);
    check("t3_next_addr", 64'(tgt_addr), 64'h108);
    check("t3_next_busy", 64'(busy), 64'd0);
    tick();
    idle_inputs();

    // error pass-through on port 1 only
    req_re[1] = 1'b1; req_addr[63:32] = 32'h10C;
    tgt_ready = 1'b1; tgt_error = 1'b1; tgt_rdata = 32'h5;
    exp_q.push_back(pack(1, 1'b1, 32'h5));
    sample();
    check("t4_other_ready", 64'(req_ready[0]), 64'd0);
    check("t4_other_error", 64'(req_error[0]), 64'd0);
    check("t4_other_rdata", 64'(req_rdata[31:0]), 64'd0);
    tick();
    idle_inputs();

    // watchdog: target never answers, port 0 times out on 4th BUSY cycle
    req_re[0] = 1'b1; req_addr[31:0] = 32'h110; tgt_rdata = 32'hFFFF_FFFF;
    sample();
    check("t5_busy_a", 64'(busy), 64'd0);
    check("t5_tgt_re_a", 64'(tgt_re), 64'd1);
    for (int b = 1; b <= 4; b++) begin
      tick();
      if (b == 4) exp_q.push_back(pack(0, 1'b1, 32'h0));
      sample();
      check("t5_busy", 64'(busy), 64'd1);
      check("t5_tgt_re", 64'(tgt_re), (b == 4) ? 64'd0 : 64'd1);
    end
    tick();
    idle_inputs();
    sample();
    check("t5_idle_after", 64'(busy), 64'd0);
    tick();

    // reset mid-access: port 1 (prio 1) stalls, reset while BUSY
    req_re[1] = 1'b1; req_addr[63:32] = 32'h114;
    sample();
    check("t6_grant_a", 64'(grant_id), 64'd1);
    tick();
    sample();
    check("t6_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_re = 2'b11;
    sample();
    check("t6_post_busy", 64'(busy), 64'd0);
    check("t6_post_grant", 64'(grant_id), 64'd0);
    check("t6_post_ready", 64'(req_ready), 64'd0);
    tick();
    idle_inputs();
    tick();
    sample();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
